// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered 32-bit arithmetic/logic unit
//
// Accepts a new operation on every rising clock edge with no handshake. The
// result, the zero flag and the signed-overflow flag for the operands and
// operation select present at an edge appear on the outputs just after that
// edge and hold until the next edge.
//
// Ports
//   clk        in   1   single clock, all state updates on the rising edge
//   reset      in   1   asynchronous, active-high; forces ALUresult=0,
//                       Zero=1, Overflow=0 and discards any in-flight result
//   ALUControl in   4   operation select (see op_e below)
//   rs         in  32   operand A; rs[4:0] is the shift amount for shifts
//   rt         in  32   operand B; the value that shift operations shift
//   ALUresult  out 32   registered operation result
//   Zero       out  1   registered; 1 when the registered ALUresult is 0
//   Overflow   out  1   registered; two's-complement overflow of ADD/SUB only
// -----------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ALUControl,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] ALUresult,
  output logic        Zero,
  output logic        Overflow
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_ADDU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLTU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLLV = 4'b1000,
    OP_SRLV = 4'b1001,
    OP_SRAV = 4'b1010,
    OP_LUI  = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_SUBU = 4'b1101,
    OP_RSV0 = 4'b1110,
    OP_RSV1 = 4'b1111
  } op_e;

  op_e op;
  assign op = op_e'(ALUControl);

  // ---------------------------------------------------------------------------
  // Shared adder/subtractor
  // ---------------------------------------------------------------------------
  logic        use_sub;
  logic [31:0] b_eff;
  logic [32:0] sum_full;
  logic [31:0] sum;
  logic        carry_out;
  logic        arith_ovf;
  logic        less_signed;
  logic        less_unsigned;

  // Subtraction is rs + ~rt + 1; both set-less-than operations reuse it.
  always_comb begin
    use_sub = (op == OP_SUB) || (op == OP_SUBU) ||
              (op == OP_SLT) || (op == OP_SLTU);
  end

  assign b_eff     = use_sub ? ~rt : rt;
  assign sum_full  = {1'b0, rs} + {1'b0, b_eff} + {32'd0, use_sub};
  assign sum       = sum_full[31:0];
  assign carry_out = sum_full[32];

  // With rt inverted for subtraction, "same sign as b_eff" becomes "signs of
  // rs and rt differ", so one expression covers both ADD and SUB overflow.
  assign arith_ovf = (rs[31] == b_eff[31]) && (sum[31] != rs[31]);

  // Correcting the difference sign by the overflow bit keeps SLT right even
  // when rs - rt does not fit in 32 bits.
  assign less_signed   = sum[31] ^ arith_ovf;

  // A subtraction that produces no carry out has borrowed: rs < rt unsigned.
  assign less_unsigned = ~carry_out;

  // ---------------------------------------------------------------------------
  // Barrel shifter
  // ---------------------------------------------------------------------------
  logic [4:0]  shamt;
  logic        shift_left;
  logic        shift_fill;
  logic [31:0] shift_in;
  logic [31:0] stage1;
  logic [31:0] stage2;
  logic [31:0] stage4;
  logic [31:0] stage8;
  logic [31:0] stage16;
  logic [31:0] shift_out;

  function automatic logic [31:0] bit_reverse(input logic [31:0] value);
    logic [31:0] reversed;
    reversed = '0;
    for (int i = 0; i < 32; i++) begin
      reversed[i] = value[31 - i];
    end
    return reversed;
  endfunction

  assign shamt      = rs[4:0];
  assign shift_left = (op == OP_SLLV);
  assign shift_fill = (op == OP_SRAV) && rt[31];

  // Left shifts are done as a right shift of the bit-reversed operand so a
  // single right-shifting network serves all three shift operations.
  assign shift_in = shift_left ? bit_reverse(rt) : rt;
  assign stage1   = shamt[0] ? {{1{shift_fill}},  shift_in[31:1]} : shift_in;
  assign stage2   = shamt[1] ? {{2{shift_fill}},  stage1[31:2]}   : stage1;
  assign stage4   = shamt[2] ? {{4{shift_fill}},  stage2[31:4]}   : stage2;
  assign stage8   = shamt[3] ? {{8{shift_fill}},  stage4[31:8]}   : stage4;
  assign stage16  = shamt[4] ? {{16{shift_fill}}, stage8[31:16]}  : stage8;
  assign shift_out = shift_left ? bit_reverse(stage16) : stage16;

  // ---------------------------------------------------------------------------
  // Result selection
  // ---------------------------------------------------------------------------
  logic [31:0] next_result;
  logic        next_zero;
  logic        next_overflow;

  always_comb begin
    next_result = '0;
    unique case (op)
      OP_AND:  next_result = rs & rt;
      OP_OR:   next_result = rs | rt;
      OP_ADD:  next_result = sum;
      OP_ADDU: next_result = sum;
      OP_XOR:  next_result = rs ^ rt;
      OP_SLTU: next_result = {31'd0, less_unsigned};
      OP_SUB:  next_result = sum;
      OP_SLT:  next_result = {31'd0, less_signed};
      OP_SLLV: next_result = shift_out;
      OP_SRLV: next_result = shift_out;
      OP_SRAV: next_result = shift_out;
      OP_LUI:  next_result = {rt[15:0], 16'h0000};
      OP_NOR:  next_result = ~(rs | rt);
      OP_SUBU: next_result = sum;
      OP_RSV0: next_result = '0;
      OP_RSV1: next_result = '0;
      default: next_result = '0;
    endcase
  end

  // Zero comes from the value about to be registered, not the current output.
  always_comb begin
    next_zero     = (next_result == 32'd0);
    next_overflow = ((op == OP_ADD) || (op == OP_SUB)) && arith_ovf;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUresult <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
    end else begin
      ALUresult <= next_result;
      Zero      <= next_zero;
      Overflow  <= next_overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu
//
// A behavioural model built from plain signed/unsigned arithmetic predicts the
// registered outputs; a compare process checks the DUT against it on every
// falling edge. Directed vectors with hand-computed literal expectations pin
// the model, followed by a run of pseudo-random operations.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  ALUControl;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] ALUresult;
  logic        Zero;
  logic        Overflow;

  int check_count = 0;
  int pass_count  = 0;

  alu dut (
    .clk        (clk),
    .reset      (reset),
    .ALUControl (ALUControl),
    .rs         (rs),
    .rt         (rt),
    .ALUresult  (ALUresult),
    .Zero       (Zero),
    .Overflow   (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic void model(input logic [3:0] ctrl, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic ovf);
    longint sa;
    longint sb;
    longint wide;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    wide = 0;
    res  = 32'd0;
    ovf  = 1'b0;
    case (ctrl)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2: begin
        wide = sa + sb;
        res  = a + b;
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd3:  res = a + b;
      4'd4:  res = a ^ b;
      4'd5:  res = (a < b) ? 32'd1 : 32'd0;
      4'd6: begin
        wide = sa - sb;
        res  = a - b;
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  res = b << a[4:0];
      4'd9:  res = b >> a[4:0];
      4'd10: res = $unsigned($signed(b) >>> a[4:0]);
      4'd11: res = {b[15:0], 16'h0000};
      4'd12: res = ~(a | b);
      4'd13: res = a - b;
      default: res = 32'd0;
    endcase
  endfunction

  logic [31:0] exp_result;
  logic        exp_zero;
  logic        exp_overflow;
  logic        model_valid = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [31:0] r;
    logic        o;
    if (reset) begin
      exp_result   <= 32'd0;
      exp_zero     <= 1'b1;
      exp_overflow <= 1'b0;
      model_valid  <= 1'b1;
    end else begin
      model(ALUControl, rs, rt, r, o);
      exp_result   <= r;
      exp_zero     <= (r == 32'd0);
      exp_overflow <= o;
    end
  end

  // Outputs are compared against the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check_count++;
      if (ALUresult === exp_result && Zero === exp_zero && Overflow === exp_overflow) begin
        pass_count++;
      end else begin
        $display("[TB] FAIL model_cmp t=%0t ctrl=%b rs=%h rt=%h got res=%h z=%b ov=%b expected res=%h z=%b ov=%b",
                 $time, ALUControl, rs, rt, ALUresult, Zero, Overflow,
                 exp_result, exp_zero, exp_overflow);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tasks
  // ---------------------------------------------------------------------------
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    ALUControl = ctrl;
    rs         = a;
    rt         = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] want_res,
                             input logic want_zero, input logic want_ovf);
    check_count++;
    if (ALUresult === want_res && Zero === want_zero && Overflow === want_ovf) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s got res=%h z=%b ov=%b expected res=%h z=%b ov=%b",
               name, ALUresult, Zero, Overflow, want_res, want_zero, want_ovf);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors (model-checked only; literals are pinned below)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[$] = '{
    '{4'b0110, 32'h80000000, 32'h00000001},
    '{4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF},
    '{4'b0111, 32'h7FFFFFFF, 32'h80000000},
    '{4'b0111, 32'h80000000, 32'h7FFFFFFF},
    '{4'b0101, 32'h00000001, 32'hFFFFFFFF},
    '{4'b0010, 32'h80000000, 32'h80000000},
    '{4'b1000, 32'h00000000, 32'hDEADBEEF},
    '{4'b1000, 32'h0000001F, 32'h00000003},
    '{4'b1001, 32'h0000001F, 32'h80000000},
    '{4'b1010, 32'h0000001F, 32'h80000000},
    '{4'b1010, 32'h00000000, 32'h80000001},
    '{4'b1001, 32'hFFFFFFE3, 32'hF0000000},
    '{4'b0100, 32'hAAAA5555, 32'hFFFF0000},
    '{4'b1101, 32'h00000000, 32'h00000001},
    '{4'b0011, 32'hFFFFFFFF, 32'h00000001},
    '{4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{4'b1111, 32'h12345678, 32'h9ABCDEF0}
  };

  initial begin
    reset      = 1'b1;
    ALUControl = 4'b0010;
    rs         = 32'd7;
    rt         = 32'd9;

    // Reset held with ADD 7+9 on the inputs and no rising edge yet.
    #3;
    checkOutput("reset_no_clock", 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("reset_held", 32'd0, 1'b1, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("first_edge_after_reset", 32'd16, 1'b0, 1'b0);

    applyStimulus(4'b1000, 32'd5, 32'd3);
    checkOutput("sllv_3_by_5", 32'h00000060, 1'b0, 1'b0);

    applyStimulus(4'b0010, 32'h7FFFFFFF, 32'd1);
    checkOutput("add_overflow", 32'h80000000, 1'b0, 1'b1);
    applyStimulus(4'b0011, 32'h7FFFFFFF, 32'd1);
    checkOutput("addu_no_overflow", 32'h80000000, 1'b0, 1'b0);

    applyStimulus(4'b0111, 32'h80000000, 32'd1);
    checkOutput("slt_negative", 32'd1, 1'b0, 1'b0);
    applyStimulus(4'b0101, 32'h80000000, 32'd1);
    checkOutput("sltu_large", 32'd0, 1'b1, 1'b0);

    applyStimulus(4'b0110, 32'h12345678, 32'h12345678);
    checkOutput("sub_equal", 32'd0, 1'b1, 1'b0);
    applyStimulus(4'b1010, 32'd4, 32'hF0000000);
    checkOutput("srav_sign_fill", 32'hFF000000, 1'b0, 1'b0);

    // Back-to-back operations on consecutive edges.
    applyStimulus(4'b0000, 32'h0F0F0F0F, 32'h00FF00FF);
    checkOutput("b2b_and", 32'h000F000F, 1'b0, 1'b0);
    applyStimulus(4'b0001, 32'h0F0F0F0F, 32'h00FF00FF);
    checkOutput("b2b_or", 32'h0FFF0FFF, 1'b0, 1'b0);
    applyStimulus(4'b1100, 32'h0F0F0F0F, 32'h00FF00FF);
    checkOutput("b2b_nor", 32'hF000F000, 1'b0, 1'b0);
    applyStimulus(4'b1011, 32'h0F0F0F0F, 32'h00FF00FF);
    checkOutput("b2b_lui", 32'h00FF0000, 1'b0, 1'b0);

    // Inputs changing between edges must not reach the outputs.
    ALUControl = 4'b0110;
    rs         = 32'd5;
    rt         = 32'd5;
    #2;
    checkOutput("hold_between_edges", 32'h00FF0000, 1'b0, 1'b0);

    applyStimulus(4'b1110, 32'hFFFFFFFF, 32'h1);
    checkOutput("reserved_op", 32'd0, 1'b1, 1'b0);
    applyStimulus(4'b0110, 32'h80000000, 32'd1);
    checkOutput("sub_overflow", 32'h7FFFFFFF, 1'b0, 1'b1);

    // Reset arriving mid-cycle discards the registered result at once.
    applyStimulus(4'b0010, 32'd7, 32'd9);
    checkOutput("add_before_reset", 32'd16, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_cycle", 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b1001, 32'd1, 32'h80000000);
    checkOutput("srlv_after_reset", 32'h40000000, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b);
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = a & 32'h0000003F;
      if (i % 7 == 0) b = a;
      applyStimulus(4'($urandom_range(0, 15)), a, b);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ALUControl  input  4  operation select.
REQ-005 rs  input  32  operand A; shift amount source for variable shifts.
REQ-006 rt  input  32  operand B; value shifted by shift operations.
REQ-007 ALUresult  output  32  registered operation result.
REQ-008 Zero  output  1  registered; 1 when the registered ALUresult equals 0.
REQ-009 Overflow  output  1  registered; two's-complement overflow of signed ADD/SUB.

Function
REQ-010 ALUresult, Zero and Overflow SHALL be registered on clk rising edge; latency one cycle from operand/control sample to output.
REQ-011 The block SHALL operate with no handshake; a new operation is accepted every cycle.
REQ-012 0000 AND: rs & rt.
REQ-013 0001 OR: rs | rt.
REQ-014 0010 ADD: rs + rt modulo 2^32; Overflow = operands same sign and result sign differs.
REQ-015 0011 ADDU: rs + rt modulo 2^32; Overflow = 0.
REQ-016 0100 XOR: rs ^ rt.
REQ-017 0101 SLTU: 1 if rs < rt unsigned, else 0 (zero-extended to 32 bits).
REQ-018 0110 SUB: rs - rt modulo 2^32; Overflow = operand signs differ and result sign differs from rs.
REQ-019 0111 SLT: 1 if rs < rt signed, else 0; SHALL be correct even when rs - rt overflows.
REQ-020 1000 SLLV: rt << rs[4:0], zero fill; rs[31:5] ignored.
REQ-021 1001 SRLV: rt >> rs[4:0], zero fill.
REQ-022 1010 SRAV: rt >> rs[4:0], sign fill from rt[31].
REQ-023 1011 LUI: {rt[15:0], 16'h0000}.
REQ-024 1100 NOR: ~(rs | rt).
REQ-025 1101 SUBU: rs - rt modulo 2^32; Overflow = 0.
REQ-026 1110, 1111 reserved: ALUresult = 0, Zero = 1, Overflow = 0.
REQ-027 Overflow SHALL be 0 for every operation other than ADD and SUB.
REQ-028 Zero SHALL be computed from the same-cycle result being registered, never from the previous output.
REQ-029 Shift amount 0 SHALL return rt unchanged; amount 31 SHALL be supported for all shifts.
REQ-030 Inputs changing between edges SHALL not affect outputs until the next rising edge.

Reset
REQ-031 While reset = 1, ALUresult = 0, Zero = 1, Overflow = 0, independent of clk.
REQ-032 Reset assertion mid-operation SHALL clear outputs immediately; the in-flight result is discarded.
REQ-033 After reset deassertion, the first rising edge SHALL register the result of the inputs present at that edge.

Verification
REQ-034 reset pulse with ALUControl=0010, rs=7, rt=9, no clock -> ALUresult=0, Zero=1, Overflow=0; after deassert and one edge -> ALUresult=16, Zero=0.
REQ-035 ALUControl=1000, rs=5, rt=3, one edge -> ALUresult=96 (0x00000060), Zero=0, Overflow=0.
REQ-036 ALUControl=0010, rs=0x7FFFFFFF, rt=1 -> ALUresult=0x80000000, Overflow=1; same operands with 0011 -> Overflow=0.
REQ-037 ALUControl=0111, rs=0x80000000, rt=1 -> ALUresult=1; ALUControl=0101, same operands -> ALUresult=0.
REQ-038 ALUControl=0110, rs=0x12345678, rt=0x12345678 -> ALUresult=0, Zero=1, Overflow=0; ALUControl=1010, rs=4, rt=0xF0000000 -> ALUresult=0xFF000000.
REQ-039 Back-to-back ops each cycle (AND, OR, NOR, LUI with rs=0x0F0F0F0F, rt=0x00FF00FF) -> results 0x000F000F, 0x0FFF0FFF, 0xF000F000, 0x00FF0000 on consecutive edges, each one cycle after its inputs.
